// File: rtl/pacman_pkg.sv
// Shared definitions for the Pacman game-mode controller.
// Contents: game_state_t enum, initial lives, score awards and ceiling,
// default frame constants and the frame counter width.
package pacman_pkg;

  typedef enum logic [2:0] {
    ST_PLAY,
    ST_REVERSAL,
    ST_RESPAWN,
    ST_GAME_OVER,
    ST_VICTORY
  } game_state_t;

  localparam logic [1:0] LIVES_INIT = 2'd3;

  localparam int SCORE_DOT   = 1;
  localparam int SCORE_FRUIT = 10;
  localparam int SCORE_GHOST = 20;
  localparam int SCORE_MAX   = 1999;

  localparam int REVERSAL_FRAMES_DEF = 600;
  localparam int RESPAWN_FRAMES_DEF  = 60;
  localparam int MOUTH_FRAMES_DEF    = 8;

  // Wide enough for the longest window (reversal, at most 600 frames).
  localparam int FRAME_CNT_W = 10;

endpackage

// File: rtl/pacman_game_ctrl_frame_tick_gen.sv
// frame_tick_gen: rising-edge detector on the VGA frame strobe feeding a
// modulo-MODULO frame counter.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   frame_clk  frame strobe level (same clock domain)
//   clr        synchronous clear, wins over counting
//   en         count frame ticks only while high
//   count      frames counted so far in the current window
//   wrap       high in the tick cycle that completes a window (count returns to 0)
module frame_tick_gen
  import pacman_pkg::*;
#(
  parameter int MODULO = 60,
  parameter int CNT_W  = FRAME_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic frame_p0;
  logic tick;

  assign tick = frame_clk & ~frame_p0;
  assign wrap = tick & en & ~clr & (count == CNT_W'(MODULO - 1));

  // Stage p0: frame strobe delayed one cycle for edge detection
  always_ff @(posedge clk) begin
    if (rst) frame_p0 <= 1'b0;
    else     frame_p0 <= frame_clk;
  end

  always_ff @(posedge clk) begin
    if (rst || clr)     count <= '0;
    else if (tick && en) count <= wrap ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/pacman_game_ctrl.sv
// pacman_game_ctrl: game-mode controller for the Pacman colour mapper.
// Consumes gameplay event pulses and the frame strobe; owns lives, score,
// the power-pellet reversal window, ghost enables, death/victory screens,
// the mouth animation flag and the respawn pulse to the motion blocks.
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   frame_clk                       VGA vsync level (Clk domain)
//   start                           restart pulse (GAME_OVER / VICTORY only)
//   dot_eaten, fruit_eaten          event pulses
//   ghost_hit[2:0]                  collision pulses {aqua, green, red}
//   dots_clear                      level, no dots remain
//   death, victory, reversal,
//   closePacman                     mode flags
//   red/green/aqua_enable           ghost visibility/collision enables
//   reversal_counter[9:0]           frames elapsed in the reversal window
//   score[10:0], lives[1:0]         HUD state
//   respawn                         one-cycle re-home pulse
module pacman_game_ctrl
  import pacman_pkg::*;
#(
  parameter int REVERSAL_FRAMES = REVERSAL_FRAMES_DEF,
  parameter int RESPAWN_FRAMES  = RESPAWN_FRAMES_DEF,
  parameter int MOUTH_FRAMES    = MOUTH_FRAMES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        dot_eaten,
  input  logic        fruit_eaten,
  input  logic [2:0]  ghost_hit,
  input  logic        dots_clear,
  output logic        death,
  output logic        victory,
  output logic        reversal,
  output logic        closePacman,
  output logic        red_enable,
  output logic        green_enable,
  output logic        aqua_enable,
  output logic [9:0]  reversal_counter,
  output logic [10:0] score,
  output logic [1:0]  lives,
  output logic        respawn
);

  function automatic logic [10:0] sat_score(input logic [10:0] cur, input logic [6:0] add);
    logic [11:0] sum;
    sum = {1'b0, cur} + {5'd0, add};
    return (sum > 12'(SCORE_MAX)) ? 11'(SCORE_MAX) : sum[10:0];
  endfunction

  game_state_t state;

  logic       in_rev, in_game;
  logic [2:0] hit_live;
  logic [1:0] n_hit;
  logic [6:0] award;
  logic       rev_clr, rev_wrap;
  logic       frz_wrap, mouth_wrap;
  logic [FRAME_CNT_W-1:0] unused_frz_count;
  logic [FRAME_CNT_W-1:0] unused_mouth_count;

  assign in_rev   = (state == ST_REVERSAL);
  assign in_game  = (state == ST_PLAY) || in_rev;
  // Only hits on currently enabled ghosts count in a reversal window.
  assign hit_live = ghost_hit & {aqua_enable, green_enable, red_enable};
  assign n_hit    = {1'b0, hit_live[0]} + {1'b0, hit_live[1]} + {1'b0, hit_live[2]};
  assign award    = (dot_eaten   ? 7'(SCORE_DOT)   : 7'd0)
                  + (fruit_eaten ? 7'(SCORE_FRUIT) : 7'd0)
                  + (in_rev ? 7'(SCORE_GHOST) * {5'd0, n_hit} : 7'd0);

  // The reversal counter is held at 0 outside the window, and is restarted by
  // a fruit or abandoned on victory; this keeps reversal_counter 0 elsewhere.
  assign rev_clr = ~in_rev | dots_clear | fruit_eaten;

  frame_tick_gen #(.MODULO(REVERSAL_FRAMES), .CNT_W(FRAME_CNT_W)) u_rev_cnt (
    .clk(Clk), .rst(Reset), .frame_clk(frame_clk), .clr(rev_clr), .en(in_rev),
    .count(reversal_counter), .wrap(rev_wrap)
  );

  frame_tick_gen #(.MODULO(RESPAWN_FRAMES), .CNT_W(FRAME_CNT_W)) u_frz_cnt (
    .clk(Clk), .rst(Reset), .frame_clk(frame_clk), .clr(state != ST_RESPAWN),
    .en(state == ST_RESPAWN), .count(unused_frz_count), .wrap(frz_wrap)
  );

  frame_tick_gen #(.MODULO(MOUTH_FRAMES), .CNT_W(FRAME_CNT_W)) u_mouth_cnt (
    .clk(Clk), .rst(Reset), .frame_clk(frame_clk), .clr(~in_game), .en(in_game),
    .count(unused_mouth_count), .wrap(mouth_wrap)
  );

  // Stage p1: mode/HUD registers, all outputs registered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_PLAY;
      lives        <= LIVES_INIT;
      score        <= '0;
      death        <= 1'b0;
      victory      <= 1'b0;
      reversal     <= 1'b0;
      closePacman  <= 1'b0;
      respawn      <= 1'b0;
      red_enable   <= 1'b1;
      green_enable <= 1'b1;
      aqua_enable  <= 1'b1;
    end else begin
      respawn <= 1'b0;
      unique case (state)
        ST_PLAY, ST_REVERSAL: begin
          score <= sat_score(score, award);
          if (in_rev) begin
            red_enable   <= red_enable   & ~ghost_hit[0];
            green_enable <= green_enable & ~ghost_hit[1];
            aqua_enable  <= aqua_enable  & ~ghost_hit[2];
          end
          if (mouth_wrap) closePacman <= ~closePacman;

          if (dots_clear) begin
            state       <= ST_VICTORY;
            victory     <= 1'b1;
            reversal    <= 1'b0;
            closePacman <= 1'b0;
          end else if (!in_rev && (ghost_hit != 3'b000)) begin
            closePacman <= 1'b0;
            if (lives == 2'd1) begin
              state <= ST_GAME_OVER;
              lives <= 2'd0;
              death <= 1'b1;
            end else begin
              state   <= ST_RESPAWN;
              lives   <= lives - 2'd1;
              respawn <= 1'b1;
            end
          end else if (fruit_eaten) begin
            state    <= ST_REVERSAL;
            reversal <= 1'b1;
          end else if (rev_wrap) begin
            state        <= ST_PLAY;
            reversal     <= 1'b0;
            red_enable   <= 1'b1;
            green_enable <= 1'b1;
            aqua_enable  <= 1'b1;
          end
        end

        ST_RESPAWN: begin
          closePacman <= 1'b0;
          if (frz_wrap) state <= ST_PLAY;
        end

        default: begin
          // GAME_OVER and VICTORY wait for start, which behaves like Reset
          // plus a respawn pulse.
          closePacman <= 1'b0;
          if (start) begin
            state        <= ST_PLAY;
            lives        <= LIVES_INIT;
            score        <= '0;
            death        <= 1'b0;
            victory      <= 1'b0;
            reversal     <= 1'b0;
            respawn      <= 1'b1;
            red_enable   <= 1'b1;
            green_enable <= 1'b1;
            aqua_enable  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Self-checking bench for pacman_game_ctrl: directed scenarios followed by
// randomized events, all checked every cycle against a rule-level model.
module tb_pacman_game_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, start, dot_eaten, fruit_eaten, dots_clear;
  logic [2:0]  ghost_hit;
  logic        death, victory, reversal, closePacman;
  logic        red_enable, green_enable, aqua_enable, respawn;
  logic [9:0]  reversal_counter;
  logic [10:0] score;
  logic [1:0]  lives;

  int n_vec = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  pacman_game_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start),
    .dot_eaten(dot_eaten), .fruit_eaten(fruit_eaten), .ghost_hit(ghost_hit),
    .dots_clear(dots_clear), .death(death), .victory(victory),
    .reversal(reversal), .closePacman(closePacman), .red_enable(red_enable),
    .green_enable(green_enable), .aqua_enable(aqua_enable),
    .reversal_counter(reversal_counter), .score(score), .lives(lives),
    .respawn(respawn)
  );

  // Reference model: game rules in terms of modes and tick counts.
  localparam int M_PLAY = 0, M_REV = 1, M_RESP = 2, M_OVER = 3, M_WIN = 4;
  localparam int WIN_REV = 600, WIN_FRZ = 60, WIN_MOUTH = 8;

  int     m_mode, m_lives, m_score, m_rev, m_frz, m_mouth;
  bit     m_close, m_respawn, m_fc_prev;
  bit [2:0] m_en;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_PLAY; m_lives = 3; m_score = 0;
    m_rev = 0; m_frz = 0; m_mouth = 0;
    m_close = 0; m_respawn = 0; m_en = 3'b111;
  endtask

  task automatic model_step();
    bit tick;
    int pts;
    tick = frame_clk && !m_fc_prev;
    m_fc_prev = frame_clk;
    if (Reset) begin
      model_reset();
      m_fc_prev = 0;
      return;
    end
    m_respawn = 0;
    if (m_mode == M_PLAY || m_mode == M_REV) begin
      pts = (dot_eaten ? 1 : 0) + (fruit_eaten ? 10 : 0);
      if (m_mode == M_REV)
        for (int g = 0; g < 3; g++)
          if (ghost_hit[g] && m_en[g]) begin
            pts += 20;
            m_en[g] = 0;
          end
      m_score = (m_score + pts > 1999) ? 1999 : m_score + pts;
      if (tick) begin
        m_mouth++;
        if (m_mouth == WIN_MOUTH) begin m_mouth = 0; m_close = !m_close; end
      end
      if (dots_clear) m_mode = M_WIN;
      else if (m_mode == M_PLAY && ghost_hit != 0) begin
        if (m_lives == 1) begin m_lives = 0; m_mode = M_OVER; end
        else begin m_lives--; m_mode = M_RESP; m_frz = 0; m_respawn = 1; end
      end else if (fruit_eaten) begin
        m_mode = M_REV; m_rev = 0;
      end else if (m_mode == M_REV && tick) begin
        m_rev++;
        if (m_rev == WIN_REV) begin m_mode = M_PLAY; m_rev = 0; m_en = 3'b111; end
      end
      if (m_mode != M_PLAY && m_mode != M_REV) begin m_close = 0; m_mouth = 0; end
      if (m_mode != M_REV) m_rev = 0;
    end else if (m_mode == M_RESP) begin
      if (tick) begin
        m_frz++;
        if (m_frz == WIN_FRZ) m_mode = M_PLAY;
      end
    end else if (start) begin
      model_reset();
      m_respawn = 1;
    end
  endtask

  task automatic compare_all();
    chk("death",       death,            m_mode == M_OVER);
    chk("victory",     victory,          m_mode == M_WIN);
    chk("reversal",    reversal,         m_mode == M_REV);
    chk("closePacman", closePacman,      m_close);
    chk("red_enable",  red_enable,       m_en[0]);
    chk("green_enable",green_enable,     m_en[1]);
    chk("aqua_enable", aqua_enable,      m_en[2]);
    chk("rev_counter", reversal_counter, (m_mode == M_REV) ? m_rev : 0);
    chk("score",       score,            m_score);
    chk("lives",       lives,            m_lives);
    chk("respawn",     respawn,          m_respawn);
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    Reset = 0; frame_clk = 0; start = 0; dot_eaten = 0;
    fruit_eaten = 0; ghost_hit = 3'b000; dots_clear = 0;
  endtask

  task automatic pulse(input bit d, input bit f, input logic [2:0] g,
                       input bit dc, input bit st, input bit rs);
    dot_eaten = d; fruit_eaten = f; ghost_hit = g;
    dots_clear = dc; start = st; Reset = rs;
    cycle();
    idle();
  endtask

  // n frame ticks, each one high cycle then one low cycle; optional dot on high cycles.
  task automatic ticks(input int n, input bit dot);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1; dot_eaten = dot;
      cycle();
      frame_clk = 0; dot_eaten = 0;
      cycle();
    end
  endtask

  initial begin
    idle();
    model_reset();
    m_fc_prev = 0;

    // Reset state
    Reset = 1;
    cycle(); cycle();
    Reset = 0;
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_enables", {aqua_enable, green_enable, red_enable}, 3'b111);

    // Dots and a fruit, then reversal hits
    repeat (5) pulse(1, 0, 3'b000, 0, 0, 0);
    pulse(0, 1, 3'b000, 0, 0, 0);
    chk("tp_score15", score, 15);
    chk("tp_rev_on", reversal, 1);
    chk("tp_rev_cnt0", reversal_counter, 0);
    pulse(0, 0, 3'b011, 0, 0, 0);
    chk("tp_ghost_score", score, 55);
    chk("tp_ghost_en", {aqua_enable, green_enable, red_enable}, 3'b100);
    pulse(0, 0, 3'b001, 0, 0, 0);
    chk("tp_dead_ghost", score, 55);

    // Reversal window expiry
    ticks(599, 0);
    chk("tp_rev_599", reversal_counter, 599);
    ticks(1, 0);
    chk("tp_rev_off", reversal, 0);
    chk("tp_rev_en", {aqua_enable, green_enable, red_enable}, 3'b111);

    // Non-fatal hit, freeze, then game over
    pulse(0, 0, 3'b010, 0, 0, 0);
    chk("tp_lives2", lives, 2);
    chk("tp_respawn_hi", respawn, 1);
    ticks(60, 1);
    chk("tp_freeze_score", score, 55);
    pulse(1, 0, 3'b000, 0, 0, 0);
    chk("tp_play_again", score, 56);
    pulse(0, 0, 3'b100, 0, 0, 0);
    ticks(60, 0);
    pulse(0, 0, 3'b001, 0, 0, 0);
    chk("tp_lives0", lives, 0);
    chk("tp_death", death, 1);
    ticks(16, 0);
    chk("tp_mouth_over", closePacman, 0);
    pulse(0, 0, 3'b000, 0, 1, 0);
    chk("tp_start_lives", lives, 3);
    chk("tp_start_score", score, 0);
    chk("tp_start_death", death, 0);
    chk("tp_start_respawn", respawn, 1);

    // Mouth toggles on the 8th tick in PLAY
    ticks(7, 0);
    chk("tp_mouth7", closePacman, 0);
    ticks(1, 0);
    chk("tp_mouth8", closePacman, 1);

    // Score saturation with simultaneous dot and dots_clear
    pulse(0, 0, 3'b000, 0, 0, 1);
    fruit_eaten = 1;
    repeat (199) cycle();
    fruit_eaten = 0;
    repeat (8) pulse(1, 0, 3'b000, 0, 0, 0);
    chk("tp_score1998", score, 1998);
    pulse(1, 0, 3'b000, 1, 0, 0);
    chk("tp_score1999", score, 1999);
    chk("tp_victory", victory, 1);
    pulse(0, 1, 3'b000, 0, 0, 0);
    chk("tp_sat_hold", score, 1999);

    // Reset in the middle of a reversal window
    pulse(0, 0, 3'b000, 0, 0, 1);
    pulse(0, 1, 3'b000, 0, 0, 0);
    ticks(300, 0);
    chk("tp_rev300", reversal_counter, 300);
    pulse(1, 1, 3'b111, 1, 1, 1);
    chk("tp_mid_rst_rev", reversal, 0);
    chk("tp_mid_rst_cnt", reversal_counter, 0);
    chk("tp_mid_rst_score", score, 0);

    // Randomized events
    for (int i = 0; i < 20000; i++) begin
      Reset       = ($urandom_range(999) == 0);
      frame_clk   = $urandom_range(1);
      start       = ($urandom_range(19) == 0);
      dot_eaten   = ($urandom_range(3) == 0);
      fruit_eaten = ($urandom_range(399) == 0);
      dots_clear  = ($urandom_range(2999) == 0);
      for (int g = 0; g < 3; g++) ghost_hit[g] = ($urandom_range(99) == 0);
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pacman_game_ctrl.md
# pacman_game_ctrl

Game-mode controller that sequences the Pacman colour-mapping datapath. It consumes gameplay event pulses and the VGA frame strobe, and owns the mode and HUD state the colour mapper renders: lives, score, the reversal (power-pellet) window and countdown, per-ghost enables, death/victory screens and the mouth-animation flag. It sits between the game-logic event sources and the colour mapper, and drives the respawn pulse back to the motion blocks.

## Interface
Parameters:
- REVERSAL_FRAMES, 600: frames per reversal window. The HUD digit is 9 - counter/60, so this must be ≤ 600.
- RESPAWN_FRAMES, 60: freeze frames after a non-fatal ghost collision.
- MOUTH_FRAMES, 8: frames per closePacman toggle.

Ports:
- Clk  in  1  system clock, the single clock domain.
- Reset  in  1  synchronous, active-high.
- frame_clk  in  1  VGA vertical-sync level, generated in the Clk domain; the block detects its rising edge.
- start  in  1  one-cycle pulse; restarts the game from GAME_OVER or VICTORY only.
- dot_eaten  in  1  one-cycle pulse.
- fruit_eaten  in  1  one-cycle pulse.
- ghost_hit  in  3  per-ghost collision pulses: [0] red, [1] green, [2] aqua.
- dots_clear  in  1  level; high when no dots remain.
- death, victory, reversal, closePacman  out  1  mode flags for the colour mapper.
- red_enable, green_enable, aqua_enable  out  1  ghost visibility and collision enables.
- reversal_counter  out  10  frames elapsed in the current reversal window.
- score  out  11  current score.
- lives  out  2  remaining lives.
- respawn  out  1  one-cycle pulse that re-homes Pacman and the ghosts.

## Operation
- States: PLAY, REVERSAL, RESPAWN, GAME_OVER, VICTORY.
- Reset values:
  - state = PLAY, lives = 3, score = 0
  - death = victory = reversal = closePacman = respawn = 0
  - all three ghost enables = 1
  - reversal_counter = 0, freeze counter = 0, mouth counter = 0
- Frame tick: frame_clk registered once; tick = frame_clk & ~frame_q.
- Scoring (PLAY and REVERSAL only): +1 for a dot, +10 for a fruit, +20 per enabled ghost hit in REVERSAL. Awards within one cycle are summed. Score saturates at 1999.
- State transitions evaluated each cycle in PLAY or REVERSAL, in priority order:
  1. dots_clear → VICTORY: victory = 1, reversal = 0.
  2. PLAY and any ghost_hit:
     - lives == 1 → GAME_OVER: lives = 0, death = 1.
     - otherwise → lives - 1, enter RESPAWN, pulse respawn, clear the freeze counter.
  3. fruit_eaten → REVERSAL: reversal = 1, reversal_counter = 0. A fruit during REVERSAL restarts the counter at 0.
- REVERSAL ghost hits: each hit on an enabled ghost clears that ghost's enable. Hits on disabled ghosts are ignored.
- REVERSAL expiry: on a tick with reversal_counter == REVERSAL_FRAMES - 1 → PLAY, reversal = 0, counter = 0, all enables = 1. Otherwise each tick increments the counter.
- RESPAWN: all events ignored. The freeze counter increments per tick; on the tick with count == RESPAWN_FRAMES - 1 → PLAY.
- GAME_OVER and VICTORY are terminal. start → PLAY with every register back at its reset value, plus a respawn pulse.
- closePacman: toggles on every MOUTH_FRAMES-th tick while in PLAY or REVERSAL. It is forced to 0 and its counter cleared in every other state.
- Outside REVERSAL, reversal_counter reads 0.

## Timing
- All outputs are registered. An event sampled in cycle n is visible in cycle n+1.
- The frame tick is asserted in the cycle after frame_clk's rising edge is sampled. Frame counters update at the end of that cycle.
- respawn is high for exactly one cycle, coincident with the first cycle in RESPAWN or the first cycle of PLAY after a start.
- A Reset pulse at any point, including mid-RESPAWN or mid-REVERSAL, restores all reset values on the next edge. Reset takes precedence over every event.
- Simultaneous dot_eaten and dots_clear: the score is awarded and victory is entered in the same update.

## Structure
- Shared package pacman_pkg holds:
  - the game_state_t enum
  - LIVES_INIT = 3
  - SCORE_DOT = 1, SCORE_FRUIT = 10, SCORE_GHOST = 20, SCORE_MAX = 1999
  - default frame constants
- Sub-module frame_tick_gen: frame_clk edge detector plus a generic modulo frame counter with clear and enable. It is instantiated for the reversal, freeze and mouth counters.

## Test plan
- Reset, 5 dot pulses, 1 fruit pulse → score = 15, reversal = 1, reversal_counter = 0. After 600 ticks: reversal = 0, all enables = 1.
- In REVERSAL, ghost_hit = 3'b011 in one cycle → score +40, red_enable = green_enable = 0, aqua_enable = 1. Repeating the red hit → no change.
- PLAY, ghost_hit at lives = 3 → lives = 2, a one-cycle respawn pulse, and dot pulses ignored for 60 ticks. Three total hits → lives = 0, death = 1; start → lives = 3, score = 0, death = 0.
- dot_eaten and dots_clear in the same cycle at score 1998 → score = 1999, victory = 1. A further fruit pulse → score unchanged.
- Reset asserted at reversal_counter = 300 → all outputs at their reset values next cycle. closePacman toggles every 8 ticks in PLAY and is held at 0 in GAME_OVER.
